// File: rtl/sha256_round_pipeline_stage_if.sv
// Handshake and data bundle for one SHA-256 round stage: upstream state/window in,
// post-round state and forwarded window out.
interface sha256_round_pipeline_stage_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] state_in;
  logic [255:0] window_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] state_out;
  logic [255:0] window_out;
  logic [5:0]   round_out;

  modport slave (
    input  in_valid,
    input  state_in,
    input  window_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output state_out,
    output window_out,
    output round_out
  );

  modport master (
    output in_valid,
    output state_in,
    output window_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  state_out,
    input  window_out,
    input  round_out
  );
endinterface

// File: rtl/sha256_round_pipeline_stage.sv
// One registered SHA-256 compression round behind a 2-entry skid buffer (main M, skid S).
// Outputs always come from M; in_ready is the registered inverse of the skid valid bit.
module sha256_round_pipeline_stage #(
  parameter logic [31:0] K_CONST   = 32'h428a2f98,
  parameter int unsigned ROUND_IDX = 0
) (
  input  logic                           CLK,
  input  logic                           RST,
  sha256_round_pipeline_stage_if.slave   bus
);

  localparam logic [5:0] ROUND_TAG = 6'(ROUND_IDX);

  // Encoding is {vM, vS}; 2'b01 is unreachable and folds back to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } fill_e;

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] choose(input logic [31:0] e, input logic [31:0] f,
                                         input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] majority(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  fill_e        fill_q, fill_d;
  logic [511:0] m_q, m_d;
  logic [511:0] s_q, s_d;

  logic         v_m, v_s;
  logic         acc, pop;
  logic [31:0]  wa, wb, wc, wd, we, wf, wg, wh, w_t;
  logic [31:0]  t1, t2;
  logic [255:0] round_state;
  logic [511:0] beat;

  assign {v_m, v_s} = fill_q;
  assign acc = bus.in_valid & ~v_s;
  assign pop = v_m & bus.out_ready;

  // Round datapath on the input side; only captured on accept.
  always_comb begin
    {wa, wb, wc, wd, we, wf, wg, wh} = bus.state_in;
    w_t         = bus.window_in[255:224];
    t1          = wh + big_sigma1(we) + choose(we, wf, wg) + K_CONST + w_t;
    t2          = big_sigma0(wa) + majority(wa, wb, wc);
    round_state = {t1 + t2, wa, wb, wc, wd + t1, we, wf, wg};
    beat        = {round_state, bus.window_in};
  end

  always_comb begin
    fill_d = fill_q;
    m_d    = m_q;
    s_d    = s_q;
    case (fill_q)
      EMPTY: begin
        if (acc) begin
          m_d    = beat;
          fill_d = ONE;
        end
      end
      ONE: begin
        if (acc && pop) begin
          m_d = beat;
        end else if (acc) begin
          s_d    = beat;
          fill_d = FULL;
        end else if (pop) begin
          fill_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          m_d    = s_q;
          fill_d = ONE;
        end
      end
      default: fill_d = EMPTY;
    endcase
  end

  // Data registers are cleared too so the outputs read zero until the first load.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fill_q <= EMPTY;
      m_q    <= '0;
      s_q    <= '0;
    end else begin
      fill_q <= fill_d;
      m_q    <= m_d;
      s_q    <= s_d;
    end
  end

  assign bus.in_ready   = ~v_s;
  assign bus.out_valid  = v_m;
  assign bus.state_out  = m_q[511:256];
  assign bus.window_out = m_q[255:0];
  assign bus.round_out  = v_m ? ROUND_TAG : 6'd0;

endmodule

// File: tb/tb_sha256_round_pipeline_stage.sv
// Directed-vector and scoreboard bench for sha256_round_pipeline_stage.
// Hand-computed round vectors plus a FIFO reference model for the handshake behaviour.
module tb_sha256_round_pipeline_stage;

  localparam logic [31:0] K0        = 32'h428a2f98;
  localparam int unsigned TB_ROUND  = 3;
  localparam int          NUM_VECS  = 9;

  typedef struct {
    logic [255:0] st;
    logic [255:0] wn;
    logic [255:0] exp_st;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [511:0] exp_q[$];
  vec_t         vecs[NUM_VECS];

  sha256_round_pipeline_stage_if bus ();

  sha256_round_pipeline_stage #(
    .K_CONST  (K0),
    .ROUND_IDX(TB_ROUND)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] w8(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d,
                                      input logic [31:0] e, input logic [31:0] f,
                                      input logic [31:0] g, input logic [31:0] h);
    return {a, b, c, d, e, f, g, h};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_round(input logic [255:0] st, input logic [255:0] wn);
    logic [31:0] w [8];
    logic [31:0] s0, s1, ch, maj, t1, t2;
    for (int i = 0; i < 8; i++) w[i] = st[255 - 32*i -: 32];
    s1  = rotr(w[4], 6) ^ rotr(w[4], 11) ^ rotr(w[4], 25);
    ch  = (w[4] & w[5]) ^ (~w[4] & w[6]);
    t1  = w[7] + s1 + ch + K0 + wn[255:224];
    s0  = rotr(w[0], 2) ^ rotr(w[0], 13) ^ rotr(w[0], 22);
    maj = (w[0] & w[1]) ^ (w[0] & w[2]) ^ (w[1] & w[2]);
    t2  = s0 + maj;
    return {t1 + t2, w[0], w[1], w[2], w[3] + t1, w[4], w[5], w[6]};
  endfunction

  task automatic check_output(input string name, input logic [255:0] act,
                              input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_against_model(input string tag);
    logic [511:0] head;
    check_output({tag, "_out_valid"}, 256'(bus.out_valid), 256'(exp_q.size() != 0));
    check_output({tag, "_in_ready"}, 256'(bus.in_ready), 256'(exp_q.size() < 2));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check_output({tag, "_state"}, bus.state_out, head[511:256]);
      check_output({tag, "_window"}, bus.window_out, head[255:0]);
      check_output({tag, "_round"}, 256'(bus.round_out), 256'(TB_ROUND));
    end else begin
      check_output({tag, "_round_idle"}, 256'(bus.round_out), 256'd0);
    end
  endtask

  task automatic check_cleared(input string tag);
    check_output({tag, "_out_valid"}, 256'(bus.out_valid), 256'd0);
    check_output({tag, "_in_ready"}, 256'(bus.in_ready), 256'd1);
    check_output({tag, "_state"}, bus.state_out, 256'd0);
    check_output({tag, "_window"}, bus.window_out, 256'd0);
    check_output({tag, "_round"}, 256'(bus.round_out), 256'd0);
  endtask

  // Drives one cycle, advances the model on the edge, then compares against it.
  task automatic apply_stimulus(input string tag, input logic iv, input logic [255:0] st,
                                input logic [255:0] wn, input logic ordy);
    logic acc, pop;
    bus.in_valid  = iv;
    bus.state_in  = st;
    bus.window_in = wn;
    bus.out_ready = ordy;
    acc = iv && (exp_q.size() < 2);
    pop = (exp_q.size() != 0) && ordy;
    @(posedge clk);
    #1;
    if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back({ref_round(st, wn), wn});
    check_against_model(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0].st     = w8(32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19);
    vecs[0].wn     = w8(32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h18);
    vecs[0].exp_st = w8(32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                        32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab);
    vecs[1].st     = '0;
    vecs[1].wn     = w8(32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77);
    vecs[1].exp_st = w8(K0, 32'h0, 32'h0, 32'h0, K0, 32'h0, 32'h0, 32'h0);
    vecs[2].st     = '0;
    vecs[2].wn     = w8(32'hffffffff, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7);
    vecs[2].exp_st = w8(32'h428a2f97, 32'h0, 32'h0, 32'h0, 32'h428a2f97, 32'h0, 32'h0, 32'h0);
    vecs[3].st     = w8(32'h0, 32'h0, 32'h0, 32'h5, 32'h0, 32'h0, 32'h0, 32'h1);
    vecs[3].wn     = w8(32'h0, 32'hdeadbeef, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hcafef00d);
    vecs[3].exp_st = w8(32'h428a2f99, 32'h0, 32'h0, 32'h0, 32'h428a2f9e, 32'h0, 32'h0, 32'h0);
    vecs[4].st     = w8(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'h0,
                        32'h0, 32'h0, 32'h0, 32'h0);
    vecs[4].wn     = w8(32'h0, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1);
    vecs[4].exp_st = w8(32'h428a2f96, 32'hffffffff, 32'hffffffff, 32'hffffffff,
                        K0, 32'h0, 32'h0, 32'h0);
    vecs[5].st     = w8(32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0);
    vecs[5].wn     = w8(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5);
    vecs[5].exp_st = w8(32'h46aa3018, 32'h0, 32'h0, 32'h0, 32'h46aa3018, 32'h1, 32'h0, 32'h0);
    vecs[6].st     = w8(32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[6].wn     = w8(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h6);
    vecs[6].exp_st = w8(32'h82923398, 32'h1, 32'h0, 32'h0, K0, 32'h0, 32'h0, 32'h0);
    vecs[7].st     = w8(32'h0, 32'h0, 32'h0, 32'h0, 32'hffffffff, 32'h12345678, 32'h0, 32'h0);
    vecs[7].wn     = w8(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7);
    vecs[7].exp_st = w8(32'h54be860f, 32'h0, 32'h0, 32'h0, 32'h54be860f, 32'hffffffff,
                        32'h12345678, 32'h0);
    vecs[8].st     = w8(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hffffffff, 32'h0);
    vecs[8].wn     = w8(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8);
    vecs[8].exp_st = w8(32'h428a2f97, 32'h0, 32'h0, 32'h0, 32'h428a2f97, 32'h0, 32'h0,
                        32'hffffffff);

    // Reset held for three edges while the inputs toggle.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.state_in  = '0;
    bus.window_in = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid  = ~bus.in_valid;
      bus.out_ready = ~bus.out_ready;
      bus.state_in  = rand256();
      bus.window_in = rand256();
      @(posedge clk);
      #1;
      check_cleared("reset_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors back-to-back; first accept lands on the first edge after release.
    for (int i = 0; i < NUM_VECS; i++) begin
      apply_stimulus("vec_model", 1'b1, vecs[i].st, vecs[i].wn, 1'b1);
      check_output($sformatf("vec%0d_state", i), bus.state_out, vecs[i].exp_st);
      check_output($sformatf("vec%0d_window", i), bus.window_out, vecs[i].wn);
    end
    apply_stimulus("vec_drain", 1'b0, '0, '0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      apply_stimulus("stream", 1'b1, rand256(), rand256(), 1'b1);
      check_output("stream_in_ready", 256'(bus.in_ready), 256'd1);
    end
    apply_stimulus("stream_drain", 1'b0, '0, '0, 1'b1);

    // Backpressure: two beats fill M and S, further offers are refused.
    apply_stimulus("bp", 1'b1, vecs[1].st, vecs[1].wn, 1'b0);
    apply_stimulus("bp", 1'b1, vecs[4].st, vecs[4].wn, 1'b0);
    check_output("bp_full_in_ready", 256'(bus.in_ready), 256'd0);
    apply_stimulus("bp", 1'b1, rand256(), rand256(), 1'b0);
    apply_stimulus("bp", 1'b1, rand256(), rand256(), 1'b0);
    check_output("bp_hold_state", bus.state_out, vecs[1].exp_st);
    apply_stimulus("bp_release", 1'b0, rand256(), rand256(), 1'b1);
    check_output("bp_second_state", bus.state_out, vecs[4].exp_st);
    apply_stimulus("bp_release", 1'b0, rand256(), rand256(), 1'b1);
    check_output("bp_drained", 256'(bus.out_valid), 256'd0);

    for (int i = 0; i < 1000; i++) begin
      apply_stimulus("random", ($urandom_range(0, 9) < 7), rand256(), rand256(),
                     ($urandom_range(0, 9) < 6));
      if (!bus.in_ready && !bus.out_valid)
        check_output("random_illegal_01", 256'(bus.out_valid), 256'd1);
    end
    for (int i = 0; i < 3; i++) apply_stimulus("random_drain", 1'b0, '0, '0, 1'b1);
    check_output("random_queue_empty", 256'(exp_q.size()), 256'd0);

    // Asynchronous reset while FULL: outputs must clear before the next edge.
    apply_stimulus("rst_mid_fill", 1'b1, vecs[5].st, vecs[5].wn, 1'b0);
    apply_stimulus("rst_mid_fill", 1'b1, vecs[6].st, vecs[6].wn, 1'b0);
    check_output("rst_mid_full", 256'(bus.in_ready), 256'd0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_cleared("rst_mid_async");
    bus.in_valid  = 1'b1;
    bus.state_in  = rand256();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_cleared("rst_mid_held");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("post_rst", 1'b1, vecs[7].st, vecs[7].wn, 1'b1);
    check_output("post_rst_state", bus.state_out, vecs[7].exp_st);
    apply_stimulus("post_rst_drain", 1'b0, '0, '0, 1'b1);
    check_output("post_rst_no_stale", 256'(bus.out_valid), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_round_pipeline_stage.md
Name: sha256_round_pipeline_stage

Overview:
- One SHA-256 compression round, registered, with a valid/ready handshake and a 2-entry skid buffer.
- Sits directly downstream of one message-schedule window stage of the double-SHA256 pipeline.
- Consumes the working state a..h and the 8-word W window produced by that stage; W_t is the window's top word.
- Forwards the updated state and the unchanged window to the next window/round stage pair, sustaining 1 transfer/cycle under backpressure.

Parameters:
- K_CONST, 32'h428a2f98, round constant K_t for this stage's round index.
- ROUND_IDX, 0, round number 0..63; informational, carried on round_out.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream holds valid state/window.
- in_ready  output  1  stage can accept; registered (no combinational path from out_ready).
- state_in  input  256  {a,b,c,d,e,f,g,h}, a in [255:224].
- window_in  input  256  {W_t..W_t+7}; W_t = window_in[255:224].
- out_valid  output  1  state_out/window_out valid.
- out_ready  input  1  downstream accepts.
- state_out  output  256  post-round {a',b',c',d',e',f',g',h'}.
- window_out  output  256  window_in, passed unchanged.
- round_out  output  6  ROUND_IDX[5:0] while out_valid; 0 otherwise.

Behaviour:
- Round arithmetic (all mod 2^32):
  - T1 = h + Σ1(e) + Ch(e,f,g) + K_CONST + W_t.
  - T2 = Σ0(a) + Maj(a,b,c).
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
  - a' = T1+T2; e' = d+T1; b'=a, c'=b, d'=c, f'=e, g'=f, h'=g.
- Computation is combinational on the input side; the result is captured into storage on accept (in_valid & in_ready).
- Storage: main register M and skid register S, each holding {state, window}, plus valid bits vM, vS.
- Outputs are always driven from M.
- States, encoded by {vM,vS}:
  - EMPTY = 00; in_ready = 1.
  - ONE = 10; in_ready = 1.
  - FULL = 11; in_ready = 0.
  - 01 is illegal and never reached.
- Transitions (acc = in_valid & in_ready; pop = out_valid & out_ready):
  - EMPTY: acc → load M, go ONE.
  - ONE:
    - acc & pop → load M, stay ONE.
    - acc & !pop → load S, go FULL.
    - !acc & pop → go EMPTY.
  - FULL: pop → M <= S, go ONE. No acc is possible in FULL.
- Timing:
  - Latency: a beat accepted at edge N is on state_out after edge N; out_valid is high from N+1.
  - Throughput: 1 beat/cycle while out_ready = 1.
  - in_ready = !vS, registered.
- Simultaneous accept and pop in ONE: the new result overwrites M in the same edge. There is no bubble and no loss.
- Ordering: strict FIFO. A beat in S is always output after the beat in M.
- While out_valid = 1 and out_ready = 0, state_out, window_out and round_out must hold stable.
- Reset (RST = 0, asynchronous, also mid-operation):
  - vM = vS = 0; out_valid = 0; in_ready = 1 after release.
  - state_out = 0, window_out = 0, round_out = 0.
  - In-flight beats are dropped.
- The first accept is possible on the first rising edge with RST = 1.
- Data registers need not be reset functionally, but outputs must read 0 during and after reset until the first load.
- in_valid with X data while in_ready = 0 must not corrupt storage.

Test Plan:
- Reset: hold RST = 0 for 3 cycles, toggle inputs → out_valid = 0, in_ready = 1, state_out = 0, round_out = 0.
- FIPS "abc" round 0:
  - Stimulus: K_CONST = 428a2f98, state_in = {6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19}, W_t = 61626380.
  - Required: one cycle later state_out = {5d6aebcd, 6a09e667, bb67ae85, 3c6ef372, fa2a4622, 510e527f, 9b05688c, 1f83d9ab}.
  - Required: window_out equals window_in.
- Streaming: 16 back-to-back beats with out_ready = 1 → 16 outputs on consecutive cycles, in order, in_ready never drops.
- Backpressure: out_ready = 0 for 4 cycles during streaming:
  - Two beats accepted, then in_ready = 0.
  - Outputs stay stable.
  - On release, both beats drain in order with no duplicates or loss.
- Random stall: 1000 beats with random in_valid/out_ready against a reference model → identical output sequence; {vM,vS} never 01.
- Reset mid-operation: assert RST while FULL → outputs clear asynchronously (before next edge); post-reset stream starts clean with no stale beats.
